axis_out_framer: RTL and testbench

Output framing stage placed directly downstream of the access-control block's AXI-Stream master port. It buffers upsampled pixel beats in a FIFO of OUT_FIFO_DEPTH entries, re-times them onto the external AXI-Stream output, and generates frame markers: tuser on the first beat of a frame and tlast on the last beat of every destination line. It also emits a one-cycle frame-done pulse for the register file.

---
 rtl/axis_out_framer.sv | 137 +++++++++++++
 tb/tb_axis_out_framer.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/axis_out_framer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : axis_out_framer                                            |
// | Description : Output FIFO plus AXI-Stream framing. It adds tuser at the  |
// |               start of each frame, tlast at each line end, and a         |
// |               frame_done pulse.                                          |
// | Option      : OUT_FRAMER_STALL_CNT_EN enables the backpressure counter   |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module axis_out_framer #(
  parameter int AXISOUT_DATA_WIDTH = 24,
  parameter int DST_IMG_WIDTH      = 3840,
  parameter int DST_IMG_HEIGHT     = 2160,
  parameter int OUT_FIFO_DEPTH     = 16
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              clr,
  input  logic                              s_axis_tvalid,
  output logic                              s_axis_tready,
  input  logic [AXISOUT_DATA_WIDTH-1:0]     s_axis_tdata,
  output logic                              m_axis_tvalid,
  input  logic                              m_axis_tready,
  output logic [AXISOUT_DATA_WIDTH-1:0]     m_axis_tdata,
  output logic [AXISOUT_DATA_WIDTH/8-1:0]   m_axis_tkeep,
  output logic                              m_axis_tlast,
  output logic                              m_axis_tuser,
  output logic                              frame_done,
  output logic [$clog2(OUT_FIFO_DEPTH):0]   fifo_level,
  output logic [31:0]                       stall_cnt
);

  localparam int AW = $clog2(OUT_FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = (DST_IMG_WIDTH  > 1) ? $clog2(DST_IMG_WIDTH)  : 1;
  localparam int RW = (DST_IMG_HEIGHT > 1) ? $clog2(DST_IMG_HEIGHT) : 1;
  localparam int KW = AXISOUT_DATA_WIDTH / 8;

  localparam logic [LW-1:0] DEPTH_LVL = LW'(OUT_FIFO_DEPTH);
  localparam logic [CW-1:0] COL_LAST  = CW'(DST_IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST  = RW'(DST_IMG_HEIGHT - 1);

  logic [AXISOUT_DATA_WIDTH-1:0] mem [OUT_FIFO_DEPTH];
  logic [AW-1:0]                 wr_ptr;
  logic [AW-1:0]                 rd_ptr;
  logic [LW-1:0]                 level;
  logic [CW-1:0]                 col;
  logic [RW-1:0]                 row;
  logic                          push;
  logic                          pop;
  logic                          col_end;
  logic                          row_end;

  // Ready follows rst_n directly so that it reads 0 while reset is held.
  // clr also blocks input, so a beat offered during a flush is never taken.
  assign s_axis_tready = rst_n && (level < DEPTH_LVL) && !clr;
  assign m_axis_tvalid = (level != '0);
  assign push          = s_axis_tvalid && s_axis_tready;
  assign pop           = m_axis_tvalid && m_axis_tready && !clr;
  assign col_end       = (col == COL_LAST);
  assign row_end       = (row == ROW_LAST);

  // Data, keep and the markers are masked while empty.
  // This gives clean zeros out of reset.
  assign m_axis_tdata = m_axis_tvalid ? mem[rd_ptr] : '0;
  assign m_axis_tkeep = m_axis_tvalid ? {KW{1'b1}} : '0;
  assign m_axis_tlast = m_axis_tvalid && col_end;
  assign m_axis_tuser = m_axis_tvalid && (col == '0) && (row == '0);
  assign fifo_level   = level;

  // Storage array; no reset needed because reads are masked by level.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= s_axis_tdata;
    end
  end

  // Pointers and occupancy; a simultaneous push and pop leaves the level unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      level <= level + 1'b1;
      else if (pop && !push) level <= level - 1'b1;
    end
  end

  // Column and row position of the head beat; both advance only on a pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col <= '0;
      row <= '0;
    end else if (clr) begin
      col <= '0;
      row <= '0;
    end else if (pop) begin
      if (col_end) begin
        col <= '0;
        row <= row_end ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  // frame_done is high for one cycle after the last beat of a frame is popped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   frame_done <= 1'b0;
    else if (clr) frame_done <= 1'b0;
    else          frame_done <= pop && col_end && row_end;
  end

`ifdef OUT_FRAMER_STALL_CNT_EN
  // Count the cycles where output is valid but held off; saturate at all ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (clr) begin
      stall_cnt <= '0;
    end else if (m_axis_tvalid && !m_axis_tready && (stall_cnt != 32'hFFFF_FFFF)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`else
  assign stall_cnt = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_axis_out_framer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_axis_out_framer                                         |
// | Description : Self-checking bench for axis_out_framer (W=4, H=2, D=4).   |
// |               A queue-based reference model supplies expected values.    |
// | Option      : honours OUT_FRAMER_STALL_CNT_EN for stall_cnt expectations |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_axis_out_framer;

  localparam int DW = 24;
  localparam int W  = 4;
  localparam int H  = 2;
  localparam int D  = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clr = 1'b0;
  logic          s_axis_tvalid = 1'b0;
  logic          s_axis_tready;
  logic [DW-1:0] s_axis_tdata = '0;
  logic          m_axis_tvalid;
  logic          m_axis_tready = 1'b0;
  logic [DW-1:0] m_axis_tdata;
  logic [2:0]    m_axis_tkeep;
  logic          m_axis_tlast;
  logic          m_axis_tuser;
  logic          frame_done;
  logic [2:0]    fifo_level;
  logic [31:0]   stall_cnt;

  axis_out_framer #(
    .AXISOUT_DATA_WIDTH(DW),
    .DST_IMG_WIDTH(W),
    .DST_IMG_HEIGHT(H),
    .OUT_FIFO_DEPTH(D)
  ) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready), .s_axis_tdata(s_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready), .m_axis_tdata(m_axis_tdata),
    .m_axis_tkeep(m_axis_tkeep), .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser),
    .frame_done(frame_done), .fifo_level(fifo_level), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  // The reference model is a queue of buffered pixels plus the frame index
  // of the head beat (number of pops modulo W*H).
  logic [DW-1:0] q[$];
  int            pos = 0;
  int            exp_fd = 0;
  longint        exp_stall = 0;
  int            fd_seen = 0;
  int            checks = 0;
  int            failures = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    logic v;
    int   stall_exp;
    v = (q.size() != 0);
`ifdef OUT_FRAMER_STALL_CNT_EN
    stall_exp = int'(exp_stall);
`else
    stall_exp = 0;
`endif
    chk("s_tready", 64'(s_axis_tready), 64'(rst_n && (q.size() < D) && !clr));
    chk("m_tvalid", 64'(m_axis_tvalid), 64'(v));
    chk("m_tdata",  64'(m_axis_tdata),  v ? 64'(q[0]) : 64'd0);
    chk("m_tkeep",  64'(m_axis_tkeep),  v ? 64'h7 : 64'd0);
    chk("m_tlast",  64'(m_axis_tlast),  64'(v && ((pos % W) == W - 1)));
    chk("m_tuser",  64'(m_axis_tuser),  64'(v && (pos == 0)));
    chk("frame_done", 64'(frame_done),  64'(exp_fd));
    chk("fifo_level", 64'(fifo_level),  64'(q.size()));
    chk("stall_cnt",  64'(stall_cnt),   64'(stall_exp));
  endtask

  // One clock cycle: drive the inputs, predict the cycle from the model,
  // then check the outputs just after the edge.
  task automatic step(input logic v, input logic [DW-1:0] d, input logic r, input logic c);
    logic push, pop;
    int   fd_next;
    s_axis_tvalid = v;
    s_axis_tdata  = d;
    m_axis_tready = r;
    clr           = c;
    push    = v && (q.size() < D) && !c;
    pop     = (q.size() != 0) && r && !c;
    fd_next = (pop && pos == W * H - 1) ? 1 : 0;
    if (c) exp_stall = 0;
    else if ((q.size() != 0) && !r && exp_stall != 64'hFFFF_FFFF) exp_stall++;
    @(posedge clk);
    #1;
    if (c) begin
      q.delete();
      pos    = 0;
      exp_fd = 0;
    end else begin
      if (pop) begin
        void'(q.pop_front());
        pos = (pos + 1) % (W * H);
      end
      if (push) q.push_back(d);
      exp_fd = fd_next;
    end
    fd_seen += int'(frame_done);
    check_outputs();
  endtask

  task automatic full_frame(input string tag);
    fd_seen = 0;
    for (int i = 1; i <= 8; i++) step(1'b1, DW'(i), 1'b1, 1'b0);
    for (int i = 0; i < 3; i++)  step(1'b0, '0, 1'b1, 1'b0);
    chk(tag, 64'(fd_seen), 64'd1);
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_outputs();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_outputs();

    // Full frame with no stalls
    full_frame("fd_count_frame1");

    // Fill to full with the output held off; beat 5 waits for a pop
    for (int i = 0; i < 5; i++) step(1'b1, DW'(24'h100 + i), 1'b0, 1'b0);
    chk("full_level", 64'(fifo_level), 64'd4);
    step(1'b1, 24'h104, 1'b1, 1'b0);
    step(1'b1, 24'h104, 1'b0, 1'b0);
    chk("beat5_taken", 64'(fifo_level), 64'd4);
    for (int i = 0; i < 6; i++) step(1'b0, '0, 1'b1, 1'b0);

    // Simultaneous push and pop at level 2, wrapping the pointers
    step(1'b1, 24'h200, 1'b0, 1'b0);
    step(1'b1, 24'h201, 1'b0, 1'b0);
    for (int i = 2; i < 9; i++) begin
      step(1'b1, DW'(24'h200 + i), 1'b1, 1'b0);
      chk("pushpop_level", 64'(fifo_level), 64'd2);
    end
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, 1'b0);

    // clr at level 3 with the head beat at column 2
    step(1'b0, '0, 1'b0, 1'b1);
    step(1'b1, 24'h300, 1'b0, 1'b0);
    step(1'b1, 24'h301, 1'b0, 1'b0);
    step(1'b1, 24'h302, 1'b1, 1'b0);
    step(1'b1, 24'h303, 1'b1, 1'b0);
    step(1'b1, 24'h304, 1'b0, 1'b0);
    chk("pre_clr_level", 64'(fifo_level), 64'd3);
    step(1'b1, 24'h3FF, 1'b1, 1'b1);
    chk("clr_tvalid", 64'(m_axis_tvalid), 64'd0);
    step(1'b1, 24'h305, 1'b0, 1'b0);
    chk("clr_tuser", 64'(m_axis_tuser), 64'd1);
    step(1'b0, '0, 1'b1, 1'b0);

    // Asynchronous reset five beats into a frame, then a fresh frame
    for (int i = 1; i <= 5; i++) step(1'b1, DW'(i), 1'b1, 1'b0);
    step(1'b1, 24'h6, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    q.delete();
    pos = 0;
    exp_fd = 0;
    exp_stall = 0;
    check_outputs();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_outputs();
    full_frame("fd_count_after_reset");

    // Backpressure counter: one beat held for 7 cycles
    step(1'b0, '0, 1'b0, 1'b1);
    step(1'b1, 24'h777, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) step(1'b0, '0, 1'b0, 1'b0);
`ifdef OUT_FRAMER_STALL_CNT_EN
    chk("stall7", 64'(stall_cnt), 64'd7);
`else
    chk("stall7", 64'(stall_cnt), 64'd0);
`endif
    step(1'b0, '0, 1'b1, 1'b0);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 3) != 0), DW'($urandom),
           1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 59) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
